ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the main decoder.
- Holds the PC and issues in-order requests to instruction memory over a ready/valid handshake.
- Buffers returned words in a small FIFO and presents the head instruction, its PC and opcode (instr[31:26]) to decode.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
PC_W, 32, PC/address width in bits
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, instruction buffer entries and maximum in-flight plus buffered requests (power of 2, ≥2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  PC_W  fetch address, word aligned
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response word valid, in request order, at most one per cycle
imem_rdata  input  32  response instruction word
redirect  input  1  branch/jump taken, one-cycle pulse
redirect_pc  input  PC_W  new fetch target
instr_valid  output  1  head instruction valid
instr_ready  input  1  decode consumes head this cycle
instr  output  32  head instruction word
instr_pc  output  PC_W  PC of head instruction
op  output  6  instr[31:26]; 0 when instr_valid=0

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; buffer empty; outstanding=0; discard=0.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, op=0.
- Credit rule: imem_req=1 iff outstanding+occupancy<DEPTH and redirect=0 and reset deasserted.
  - imem_addr=fetch_pc whenever imem_req=1.
- Request accepted when imem_req&&imem_ready:
  - fetch_pc+=4, wrapping modulo 2^PC_W.
  - outstanding+=1.
- Response handling when imem_rvalid=1:
  - discard>0: drop the word; discard-=1; outstanding-=1.
  - discard=0: push {imem_rdata, tag PC} to FIFO tail; outstanding-=1.
  - Tag PC comes from an internal response-PC counter that advances by 4 per accepted response.
- Latency: a response pushed at edge N is visible on instr/instr_valid after edge N. No combinational bypass from imem_rdata to instr.
- Pop when instr_valid&&instr_ready; head advances.
  - Simultaneous push and pop is legal at any occupancy.
  - The credit rule guarantees no push when full.
- Outstanding counter nets accept and response in the same cycle.
- Redirect cycle (redirect=1):
  - No request issued.
  - FIFO flushed, including any pop and push in that cycle.
  - fetch_pc and response-PC counter <= redirect_pc.
  - discard <= outstanding + (accept this cycle? 0, impossible since req=0) − (rvalid this cycle? 1 : 0) + discard adjustment. The rvalid word arriving in the redirect cycle is dropped.
  - instr_valid=0 the cycle after the redirect.
  - First request to redirect_pc is issued the following cycle, subject to credit.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- instr_ready=1 while instr_valid=0 is ignored.
- imem_rvalid with outstanding=0 is a protocol error: ignored, counters unchanged.
- Misaligned redirect_pc: bits[1:0] are forced to 0.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched (32-bit): count of words pushed to the FIFO.
  - Adds perf_dropped (32-bit): count of words discarded after a redirect.
  - Adds perf_stall (32-bit): cycles with instr_valid=0 and no redirect.
  - All counters saturate at 2^32−1 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after each accept, instr_ready=1 -> addresses 0,4,8,… issued; instr_pc sequence 0,4,8; op matches rdata[31:26] (e.g. 0x8C000000 gives op=100011).
- instr_ready=0 with streaming memory -> exactly DEPTH=2 requests issued, then imem_req=0. After one pop, exactly one new request issues.
- imem_ready=0 for 5 cycles -> imem_addr stays at 0x8 and fetch_pc does not advance. After ready rises, the request at 0x8 is accepted once.
- Redirect to 0x100 with 2 requests in flight -> both late responses dropped; instr_valid=0; next instr_pc=0x100.
- Redirect in the same cycle as rvalid and a pop at full buffer -> buffer empty; arriving word dropped; no underflow of outstanding.
- Assert reset mid-stream with 1 outstanding -> all outputs 0 immediately; after release, fetch restarts at RESET_PC. With FETCH_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests and an in-order response buffer feeding decode.
// Optional saturating performance counters are enabled with the FETCH_PERF_EN macro.
module ifetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [5:0]      op
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall
`endif
);

    localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_LIM  = (CNT_W + 1)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(3'd4);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(2'b11));

    logic [PC_W-1:0]  fetch_pc_r;
    logic [PC_W-1:0]  resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      buf_word_r [DEPTH];
    logic [PC_W-1:0]  buf_pc_r   [DEPTH];

    logic             credit_s;
    logic             accept_s;
    logic             rsp_s;
    logic             drop_s;
    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [PC_W-1:0]  target_s;

    // Handshake qualification; a response with nothing outstanding is ignored entirely.
    always_comb begin
        credit_s          = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_LIM;
        imem_req          = reset & credit_s & ~redirect;
        imem_addr         = fetch_pc_r;
        accept_s          = imem_req & imem_ready;
        rsp_s             = imem_rvalid & (outstanding_r != {CNT_W{1'b0}});
        drop_s            = rsp_s & (redirect | (discard_r != {CNT_W{1'b0}}));
        push_s            = rsp_s & ~drop_s;
        pop_s             = instr_valid & instr_ready & ~redirect;
        outstanding_nxt_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(rsp_s);
        target_s          = redirect_pc & ALIGN_MASK;
    end

    // Head of the buffer presented to decode, zeroed while empty.
    always_comb begin
        instr_valid = (count_r != {CNT_W{1'b0}});
        instr       = instr_valid ? buf_word_r[rd_ptr_r] : 32'h0000_0000;
        instr_pc    = instr_valid ? buf_pc_r[rd_ptr_r] : {PC_W{1'b0}};
        op          = instr[31:26];
    end

    // PC, response-tag PC and request bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            if (redirect) begin
                fetch_pc_r <= target_s;
                resp_pc_r  <= target_s;
                // Everything still in flight after this cycle belongs to the old path.
                discard_r  <= outstanding_nxt_s;
            end else begin
                if (accept_s) begin
                    fetch_pc_r <= fetch_pc_r + PC_STEP;
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + PC_STEP;
                end
                if (drop_s) begin
                    discard_r <= discard_r - CNT_W'(1'b1);
                end
            end
        end
    end

    // Buffer occupancy and pointers; a redirect flushes regardless of push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (redirect) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r  <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_s);
        end
    end

    // Buffer storage; contents are only observed through the valid-masked head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_word_r[wr_ptr_r] <= imem_rdata;
            buf_pc_r[wr_ptr_r]   <= resp_pc_r;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        sat_inc = (en && (value != 32'hFFFF_FFFF)) ? (value + 32'd1) : value;
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            perf_fetched <= sat_inc(perf_fetched, push_s);
            perf_dropped <= sat_inc(perf_dropped, drop_s);
            perf_stall   <= sat_inc(perf_stall, ~instr_valid & ~redirect);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a queue-based memory answers one cycle after each accept unless held.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  op;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall;
`endif

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic        hold;
    logic        spur;
    logic [31:0] pend_q[$];
    logic [31:0] iss_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_w_q[$];
    logic [31:0] pop_op_q[$];

    ifetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .op          (op)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: opcode 0x23 plus word index, low bits echo the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] o;
        o = 6'h23 + a[7:2];
        return {o, a[25:0]};
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_logs();
        iss_q.delete();
        pop_pc_q.delete();
        pop_w_q.delete();
        pop_op_q.delete();
    endtask

    // One clock: drive the memory response, log accepts/pops, then advance the model.
    task automatic step();
        logic        acc;
        logic        was_rv;
        logic [31:0] a;
        logic [31:0] dummy;
        #1;
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (!hold && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0000_0000;
        end
        #1;
        acc    = imem_req && imem_ready;
        a      = imem_addr;
        was_rv = imem_rvalid && !spur;
        if (acc) iss_q.push_back(a);
        if (instr_valid && instr_ready && !redirect) begin
            pop_pc_q.push_back(instr_pc);
            pop_w_q.push_back(instr);
            pop_op_q.push_back({26'd0, op});
        end
        @(posedge clk);
        #1;
        if (was_rv) dummy = pend_q.pop_front();
        if (acc) pend_q.push_back(a);
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        hold        = 1'b0;
        spur        = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        pend_q.delete();
        clear_logs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1; hold = 1'b0; spur = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_pc", instr_pc, 32'h0);
        check_val("rst_op", 32'(op), 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check_val("rst_perf_stall", perf_stall, 32'd0);
`endif

        // Streaming fetch with decode always ready.
        reset = 1'b1;
        clear_logs();
        repeat (8) step();
        check_val("t1_iss0", q_at(iss_q, 0), 32'h0);
        check_val("t1_iss1", q_at(iss_q, 1), 32'h4);
        check_val("t1_iss2", q_at(iss_q, 2), 32'h8);
        check_val("t1_pc0", q_at(pop_pc_q, 0), 32'h0);
        check_val("t1_pc1", q_at(pop_pc_q, 1), 32'h4);
        check_val("t1_pc2", q_at(pop_pc_q, 2), 32'h8);
        check_val("t1_w0", q_at(pop_w_q, 0), 32'h8C00_0000);
        check_val("t1_w2", q_at(pop_w_q, 2), 32'h9400_0008);
        check_val("t1_op0", q_at(pop_op_q, 0), 32'h23);
        check_val("t1_op2", q_at(pop_op_q, 2), 32'h25);

        // Decode stalled: credit limits to DEPTH requests, one pop frees exactly one.
        apply_reset();
        instr_ready = 1'b0;
        reset = 1'b1;
        repeat (6) step();
        check_val("t2_iss_cnt", 32'(iss_q.size()), 32'd2);
        check_val("t2_req_off", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        repeat (4) step();
        check_val("t2_iss_cnt2", 32'(iss_q.size()), 32'd3);
        check_val("t2_iss2", q_at(iss_q, 2), 32'h8);
        check_val("t2_head_pc", instr_pc, 32'h4);

        // Memory not ready: address holds, then a single accept.
        apply_reset();
        reset = 1'b1;
        repeat (2) step();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t3_addr_hold", imem_addr, 32'h8);
        end
        check_val("t3_iss_cnt", 32'(iss_q.size()), 32'd2);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        check_val("t3_iss_cnt2", 32'(iss_q.size()), 32'd3);
        check_val("t3_iss2", q_at(iss_q, 2), 32'h8);
        check_val("t3_addr_next", imem_addr, 32'hC);

        // Redirect (misaligned target) with two requests in flight.
        apply_reset();
        hold = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        check_val("t4_credit_full", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check_val("t4_req_redirect", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        hold = 1'b0;
        clear_logs();
        check_val("t4_valid_after", 32'(instr_valid), 32'd0);
        check_val("t4_addr", imem_addr, 32'h100);
        repeat (7) step();
        check_val("t4_pc0", q_at(pop_pc_q, 0), 32'h100);
        check_val("t4_w0", q_at(pop_w_q, 0), 32'h8C00_0100);
        check_val("t4_pc1", q_at(pop_pc_q, 1), 32'h104);
`ifdef FETCH_PERF_EN
        check_val("t4_perf_dropped", perf_dropped, 32'd2);
`endif

        // Redirect coinciding with a legal response and a pop.
        apply_reset();
        instr_ready = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check_val("t5a_valid_pre", 32'(instr_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        check_val("t5a_flushed", 32'(instr_valid), 32'd0);
        #1;
        check_val("t5a_req", 32'(imem_req), 32'd1);
        clear_logs();
        repeat (5) step();
        check_val("t5a_pc0", q_at(pop_pc_q, 0), 32'h300);

        // Full buffer: redirect with pop and a spurious response must not underflow.
        apply_reset();
        instr_ready = 1'b0;
        reset = 1'b1;
        repeat (5) step();
        check_val("t5b_full_req", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        spur = 1'b1;
        step();
        redirect = 1'b0;
        spur = 1'b0;
        check_val("t5b_flushed", 32'(instr_valid), 32'd0);
        check_val("t5b_op", 32'(op), 32'd0);
        #1;
        check_val("t5b_req", 32'(imem_req), 32'd1);
        check_val("t5b_addr", imem_addr, 32'h200);
        clear_logs();
        repeat (5) step();
        check_val("t5b_pc0", q_at(pop_pc_q, 0), 32'h200);
        check_val("t5b_w0", q_at(pop_w_q, 0), 32'h8C00_0200);

        // Asynchronous reset mid-stream with one request outstanding.
        apply_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check_val("t6_req", 32'(imem_req), 32'd0);
        check_val("t6_valid", 32'(instr_valid), 32'd0);
        check_val("t6_instr", instr, 32'h0);
        check_val("t6_pc", instr_pc, 32'h0);
        check_val("t6_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check_val("t6_perf_fetched", perf_fetched, 32'd0);
        check_val("t6_perf_dropped", perf_dropped, 32'd0);
        check_val("t6_perf_stall", perf_stall, 32'd0);
`endif
        apply_reset();
        reset = 1'b1;
        repeat (6) step();
        check_val("t6_iss0", q_at(iss_q, 0), 32'h0);
        check_val("t6_iss1", q_at(iss_q, 1), 32'h4);
        check_val("t6_pc0", q_at(pop_pc_q, 0), 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
